// File: rtl/cnl_job_sweep_sequencer.sv
// cnl_job_sweep_sequencer: walks a size x stride x pad x kernel grid, issues one quad job per point and checks its result beat count.
module cnl_job_sweep_sequencer #(
  parameter int NUM_SIZES      = 2,
  parameter int NUM_STRIDES    = 2,
  parameter int NUM_PADS       = 2,
  parameter int NUM_KCFGS      = 5,
  parameter int KERNEL_SIZE    = 3,
  parameter int DEPTH          = 4,
  parameter int MAX_INPUT_COLS = 64,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic         clk_if,
  input  logic         rst,
  input  logic         cfg_wr_en,
  input  logic [1:0]   cfg_wr_sel,
  input  logic [3:0]   cfg_wr_idx,
  input  logic [15:0]  cfg_wr_data,
  input  logic         sweep_start,
  input  logic         sweep_abort,
  output logic         job_start,
  input  logic         job_accept,
  output logic [127:0] job_parameters,
  input  logic         job_complete,
  output logic         job_complete_ack,
  input  logic         result_valid,
  output logic         result_accept,
  output logic         sweep_busy,
  output logic         sweep_done,
  output logic [15:0]  cur_test_idx,
  output logic [15:0]  pass_count,
  output logic [15:0]  fail_count,
  output logic [15:0]  last_fail_idx,
  output logic         timeout_err
);
  localparam int SW = NUM_SIZES   > 1 ? $clog2(NUM_SIZES)   : 1;
  localparam int TW = NUM_STRIDES > 1 ? $clog2(NUM_STRIDES) : 1;
  localparam int PW = NUM_PADS    > 1 ? $clog2(NUM_PADS)    : 1;
  localparam int KW = NUM_KCFGS   > 1 ? $clog2(NUM_KCFGS)   : 1;
  localparam logic [SW-1:0] SL = SW'(NUM_SIZES - 1);
  localparam logic [TW-1:0] TL = TW'(NUM_STRIDES - 1);
  localparam logic [PW-1:0] PL = PW'(NUM_PADS - 1);
  localparam logic [KW-1:0] KL = KW'(NUM_KCFGS - 1);
  typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, ACK, NEXT, DONE} state_t;
  state_t st;
  logic [15:0] size_tab [NUM_SIZES];
  logic [3:0]  stride_tab [NUM_STRIDES];
  logic [15:0] pad_tab [NUM_PADS];
  logic [15:0] kern_tab [NUM_KCFGS];
  logic [SW-1:0] si;
  logic [TW-1:0] ti;
  logic [PW-1:0] pi;
  logic [KW-1:0] ki;
  logic [31:0] beat_cnt, expected, to_cnt, exp_n, o32;
  logic [17:0] pad2, padded, eff_pad, o;
  logic [15:0] sz, pd, kn, eff;
  logic [3:0]  sd;
  logic [1:0]  sh;
  logic        skip, k_w, p_w, t_w, s_w;
  always_ff @(posedge clk_if)
    if (cfg_wr_en && !sweep_busy) begin
      if (cfg_wr_sel == 2'd0 && {28'd0, cfg_wr_idx} < NUM_SIZES)   size_tab[cfg_wr_idx[SW-1:0]]   <= cfg_wr_data;
      if (cfg_wr_sel == 2'd1 && {28'd0, cfg_wr_idx} < NUM_STRIDES) stride_tab[cfg_wr_idx[TW-1:0]] <= cfg_wr_data[3:0];
      if (cfg_wr_sel == 2'd2 && {28'd0, cfg_wr_idx} < NUM_PADS)    pad_tab[cfg_wr_idx[PW-1:0]]    <= cfg_wr_data;
      if (cfg_wr_sel == 2'd3 && {28'd0, cfg_wr_idx} < NUM_KCFGS)   kern_tab[cfg_wr_idx[KW-1:0]]   <= cfg_wr_data;
    end
  // Clamp oversized padded images to the quad limit, then derive the output edge and beat volume.
  always_comb begin
    sz      = size_tab[si];
    sd      = stride_tab[ti];
    pd      = pad_tab[pi];
    kn      = kern_tab[ki];
    pad2    = {1'b0, pd, 1'b0};
    padded  = {2'b0, sz} + pad2;
    eff     = padded > 18'(MAX_INPUT_COLS) ? 16'(18'(MAX_INPUT_COLS) - pad2) : sz;
    eff_pad = {2'b0, eff} + pad2;
    skip    = eff_pad < 18'(KERNEL_SIZE);
    sh      = sd[3] ? 2'd3 : sd[2] ? 2'd2 : sd[1] ? 2'd1 : 2'd0;
    o       = ((eff_pad - 18'(KERNEL_SIZE)) >> sh) + 18'd1;
    o32     = 32'(o);
    exp_n   = o32 * o32 * {16'd0, kn};
    k_w     = ki == KL;
    p_w     = k_w && pi == PL;
    t_w     = p_w && ti == TL;
    s_w     = t_w && si == SL;
  end
  always_ff @(posedge clk_if) begin
    if (rst) begin
      st <= IDLE;
      job_start <= 1'b0;
      job_parameters <= '0;
      job_complete_ack <= 1'b0;
      result_accept <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      cur_test_idx <= '0;
      pass_count <= '0;
      fail_count <= '0;
      last_fail_idx <= '0;
      timeout_err <= 1'b0;
      si <= '0;
      ti <= '0;
      pi <= '0;
      ki <= '0;
      beat_cnt <= '0;
      expected <= '0;
      to_cnt <= '0;
    end else if (sweep_abort) begin
      st <= IDLE;
      job_start <= 1'b0;
      job_complete_ack <= 1'b0;
      result_accept <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (st)
        IDLE: if (sweep_start) begin
          st <= PREP;
          sweep_busy <= 1'b1;
          cur_test_idx <= '0;
          pass_count <= '0;
          fail_count <= '0;
          last_fail_idx <= '0;
          timeout_err <= 1'b0;
          si <= '0;
          ti <= '0;
          pi <= '0;
          ki <= '0;
        end
        PREP: if (skip) st <= NEXT;
        else begin
          st <= ISSUE;
          job_start <= 1'b1;
          expected <= exp_n;
          job_parameters <= {16'd0, cur_test_idx, 16'd0, pd[3:0], sd, 8'(KERNEL_SIZE), kn, 16'(DEPTH), eff, eff};
        end
        ISSUE: if (job_accept) begin
          st <= WAIT;
          job_start <= 1'b0;
          result_accept <= 1'b1;
          beat_cnt <= '0;
          to_cnt <= '0;
        end
        WAIT: begin
          if (result_valid && beat_cnt != '1) beat_cnt <= beat_cnt + 32'd1;
          if (job_complete) begin
            st <= ACK;
            result_accept <= 1'b0;
            job_complete_ack <= 1'b1;
          end else if (to_cnt == TIMEOUT_CYCLES - 1) begin
            st <= IDLE;
            result_accept <= 1'b0;
            sweep_busy <= 1'b0;
            timeout_err <= 1'b1;
            fail_count <= fail_count + 16'd1;
          end else to_cnt <= to_cnt + 32'd1;
        end
        ACK: begin
          st <= NEXT;
          job_complete_ack <= 1'b0;
          if (beat_cnt == expected) pass_count <= pass_count + 16'd1;
          else begin
            fail_count <= fail_count + 16'd1;
            last_fail_idx <= cur_test_idx;
          end
        end
        NEXT: begin
          cur_test_idx <= cur_test_idx + 16'd1;
          ki <= k_w ? '0 : ki + 1'b1;
          if (k_w) pi <= pi == PL ? '0 : pi + 1'b1;
          if (p_w) ti <= ti == TL ? '0 : ti + 1'b1;
          if (t_w) si <= si == SL ? '0 : si + 1'b1;
          st <= s_w ? DONE : PREP;
          sweep_done <= s_w;
        end
        DONE: begin
          st <= IDLE;
          sweep_done <= 1'b0;
          sweep_busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnl_job_sweep_sequencer.sv
// tb_cnl_job_sweep_sequencer: directed sweeps with a scripted quad responder and hand-computed beat volumes.
module tb_cnl_job_sweep_sequencer;
  localparam int TO = 8192;
  logic         clk_if = 0, rst = 1;
  logic         cfg_wr_en = 0, sweep_start = 0, sweep_abort = 0;
  logic [1:0]   cfg_wr_sel = 0;
  logic [3:0]   cfg_wr_idx = 0;
  logic [15:0]  cfg_wr_data = 0;
  logic         job_accept = 0, job_complete = 0, result_valid = 0;
  logic         job_start, job_complete_ack, result_accept, sweep_busy, sweep_done, timeout_err;
  logic [127:0] job_parameters;
  logic [15:0]  cur_test_idx, pass_count, fail_count, last_fail_idx;
  int n_chk = 0, n_fail = 0, done_cnt = 0, js_cnt = 0;
  logic [15:0] sz_t [2], st_t [2], pd_t [2], kn_t [5];
  int base8 [8] = '{9, 25, 4, 9, 324, 400, 81, 100};
  cnl_job_sweep_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_if(clk_if), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_data(cfg_wr_data), .sweep_start(sweep_start), .sweep_abort(sweep_abort), .job_start(job_start),
    .job_accept(job_accept), .job_parameters(job_parameters), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack), .result_valid(result_valid), .result_accept(result_accept),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .cur_test_idx(cur_test_idx), .pass_count(pass_count),
    .fail_count(fail_count), .last_fail_idx(last_fail_idx), .timeout_err(timeout_err));
  always #5 clk_if = ~clk_if;
  always @(negedge clk_if) begin
    if (sweep_done) done_cnt++;
    if (job_start) js_cnt++;
  end
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask
  task automatic cfg(input logic [1:0] sel, input logic [3:0] idx, input logic [15:0] d);
    cfg_wr_en = 1; cfg_wr_sel = sel; cfg_wr_idx = idx; cfg_wr_data = d;
    tick();
    cfg_wr_en = 0;
  endtask
  task automatic load_tables();
    for (int i = 0; i < 2; i++) begin
      cfg(2'd0, 4'(i), sz_t[i]);
      cfg(2'd1, 4'(i), st_t[i]);
      cfg(2'd2, 4'(i), pd_t[i]);
    end
    for (int i = 0; i < 5; i++) cfg(2'd3, 4'(i), kn_t[i]);
  endtask
  task automatic pulse_start();
    sweep_start = 1;
    tick();
    sweep_start = 0;
  endtask
  task automatic wait_start();
    for (int n = 0; n < 100 && !job_start; n++) tick();
    check("job_start_seen", {127'd0, job_start}, 128'd1);
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 200 && sweep_busy; n++) tick();
    check("idle_reached", {127'd0, sweep_busy}, 128'd0);
  endtask
  task automatic serve(input int beats, input int hold, output logic [127:0] p);
    int bad;
    wait_start();
    p = job_parameters;
    bad = 0;
    for (int n = 0; n < hold; n++) begin
      tick();
      if (!job_start || job_parameters !== p) bad++;
    end
    if (hold > 0) check("accept_hold", 128'(bad), 128'd0);
    job_accept = 1;
    tick();
    job_accept = 0;
    result_valid = 1;
    repeat (beats) tick();
    result_valid = 0;
    job_complete = 1;
    tick();
    job_complete = 0;
    check("ack", {127'd0, job_complete_ack}, 128'd1);
    tick();
  endtask
  function automatic logic [127:0] exp_par(input int idx);
    logic [15:0] s, t, pd, k;
    s = sz_t[idx / 20]; t = st_t[(idx / 10) % 2]; pd = pd_t[(idx / 5) % 2]; k = kn_t[idx % 5];
    return {16'd0, 16'(idx), 16'd0, pd[3:0], t[3:0], 8'd3, k, 16'd4, s, s};
  endfunction
  function automatic logic [127:0] outs();
    return {56'd0, job_start, job_complete_ack, result_accept, sweep_busy, sweep_done, timeout_err, 2'd0,
            cur_test_idx, pass_count, fail_count, last_fail_idx};
  endfunction
  initial begin
    logic [127:0] p;
    int d0, j0, n;
    repeat (2) tick();
    rst = 0;
    check("reset_outs", outs(), 128'd0);
    check("reset_params", job_parameters, 128'd0);
    sz_t = '{16'd5, 16'd20}; st_t = '{16'd1, 16'd2}; pd_t = '{16'd0, 16'd1}; kn_t = '{16'd1, 16'd11, 16'd2, 16'd3, 16'd4};
    load_tables();
    sweep_start = 1; sweep_abort = 1;
    tick();
    sweep_start = 0; sweep_abort = 0;
    check("abort_beats_start", {127'd0, sweep_busy}, 128'd0);
    d0 = done_cnt;
    pulse_start();
    check("busy_after_start", {127'd0, sweep_busy}, 128'd1);
    for (int i = 0; i < 40; i++) begin
      serve(base8[i / 5] * int'(kn_t[i % 5]) - (i == 7 ? 1 : 0), i == 0 ? 100 : 0, p);
      check($sformatf("params%0d", i), p, exp_par(i));
      if (i == 0) begin
        check("p0_low", {64'd0, p[63:0]}, 128'h0001_0004_0005_0005);
        check("pass_after_p0", 128'(pass_count), 128'd1);
      end
      if (i == 7) check("fail_after_p7", 128'(fail_count), 128'd1);
    end
    wait_idle();
    check("main_pass", 128'(pass_count), 128'd39);
    check("main_fail", 128'(fail_count), 128'd1);
    check("main_last_fail", 128'(last_fail_idx), 128'd7);
    check("main_idx", 128'(cur_test_idx), 128'd40);
    check("main_done", 128'(done_cnt - d0), 128'd1);
    check("main_timeout", {127'd0, timeout_err}, 128'd0);
    sz_t = '{16'd1, 16'd2}; pd_t = '{16'd0, 16'd0};
    load_tables();
    d0 = done_cnt; j0 = js_cnt;
    pulse_start();
    wait_idle();
    check("skip_idx", 128'(cur_test_idx), 128'd40);
    check("skip_counts", {96'd0, pass_count, fail_count}, 128'd0);
    check("skip_no_jobs", 128'(js_cnt - j0), 128'd0);
    check("skip_done", 128'(done_cnt - d0), 128'd1);
    sz_t = '{16'd64, 16'd5}; st_t = '{16'd2, 16'd1}; pd_t = '{16'd1, 16'd0}; kn_t = '{16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
    load_tables();
    d0 = done_cnt;
    pulse_start();
    serve(1922, 0, p);
    check("clamp_low", {64'd0, p[63:0]}, 128'h0002_0004_003E_003E);
    check("clamp_high", {64'd0, p[127:64]}, 128'h1203);
    check("clamp_pass", {96'd0, pass_count, fail_count}, {96'd0, 16'd1, 16'd0});
    wait_start();
    sweep_abort = 1;
    tick();
    sweep_abort = 0;
    check("abort_strobes", {125'd0, sweep_busy, job_start, result_accept}, 128'd0);
    check("abort_hold_pass", 128'(pass_count), 128'd1);
    pulse_start();
    wait_start();
    job_accept = 1;
    tick();
    job_accept = 0;
    n = 0;
    while (n < TO + 20 && !timeout_err) begin
      tick();
      n++;
    end
    check("timeout_cycle", 128'(n), 128'(TO));
    check("timeout_state", {126'd0, sweep_busy, result_accept}, 128'd0);
    check("timeout_fail", 128'(fail_count), 128'd1);
    repeat (3) tick();
    check("timeout_no_done", 128'(done_cnt - d0), 128'd0);
    pulse_start();
    check("start_clears_timeout", {127'd0, timeout_err}, 128'd0);
    wait_start();
    job_accept = 1;
    tick();
    job_accept = 0;
    result_valid = 1;
    repeat (5) tick();
    check("in_wait", {126'd0, result_accept, sweep_busy}, 128'd3);
    rst = 1;
    tick();
    rst = 0; result_valid = 0;
    check("rst_wait_outs", outs(), 128'd0);
    check("rst_wait_params", job_parameters, 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
